// File: rtl/shift_left_seq.sv
// ---------------------------------------------------------------------------
// shift_left_seq
//
// Multi-cycle shift-left sequencer. A word and a shift amount are accepted
// through a start/ready handshake; the word is then shifted left by one bit
// position per clock for the (clamped) amount. The result, the bits that
// fell out of the MSB and an overflow flag are held with done=1 until the
// consumer acknowledges.
//
// Parameters
//   WIDTH  data word width in bits (>= 2)
//   AMT_W  width of the shift-amount input; amounts > WIDTH clamp to WIDTH
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  request, sampled only when ready=1
//   A      operand word, latched on an accepted start
//   amt    shift amount, latched on an accepted start
//   ack    consumer accepts the result, sampled only while done=1
//   abort  synchronous cancel, overrides start and ack
//   ready  1 while idle
//   busy   1 while shifting
//   done   1 while the result is held; out/spill/ovf are valid
//   out    shifted word
//   spill  bits shifted out of the MSB, most recent in bit 0
//   ovf    1 if any shifted-out bit was 1
// ---------------------------------------------------------------------------
module shift_left_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [AMT_W-1:0] amt,
    input  logic             ack,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] spill,
    output logic             ovf
);

    // Counter must be able to hold WIDTH itself (full-width shift).
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] amt_clamp;
    logic [31:0]      amt_ext;

    // Amount clamp: anything beyond WIDTH shifts the whole word out.
    always_comb begin
        amt_ext = 32'(amt);
        if (amt_ext > 32'(WIDTH)) begin
            amt_clamp = CNT_W'(WIDTH);
        end else begin
            amt_clamp = CNT_W'(amt_ext);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (amt_clamp == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // cnt==1 means the shift happening on this edge is the last.
                if (cnt == CNT_W'(1)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
        end
    end

    // Output decode: pure function of the state register, so the status
    // flags have no combinational path from any input.
    always_comb begin
        ready = (state == S_IDLE);
        busy  = (state == S_SHIFT);
        done  = (state == S_DONE);
    end

    // Datapath: operand/result word, spill collector, overflow and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            spill <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else if (abort) begin
            out   <= '0;
            spill <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        out   <= A;
                        spill <= '0;
                        ovf   <= 1'b0;
                        cnt   <= amt_clamp;
                    end
                end
                S_SHIFT: begin
                    out   <= {out[WIDTH-2:0], 1'b0};
                    spill <= {spill[WIDTH-2:0], out[WIDTH-1]};
                    ovf   <= ovf | out[WIDTH-1];
                    cnt   <= cnt - CNT_W'(1);
                end
                default: begin
                    // DONE holds the result; nothing changes until ack/abort.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_left_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_left_seq
//
// Self-checking bench for shift_left_seq (WIDTH=8, AMT_W=4). Expected
// results come from treating the shift as a plain double-width arithmetic
// shift: {0,A} << k, whose low half is out and high half is spill.
// ---------------------------------------------------------------------------
module tb_shift_left_seq;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  A;
    logic [AW-1:0] amt;
    logic          ack;
    logic          abort;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  out;
    logic [W-1:0]  spill;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    shift_left_seq #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .amt   (amt),
        .ack   (ack),
        .abort (abort),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .spill (spill),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: double-width shift, low half = out, high half = spill.
    function automatic logic [2*W-1:0] ref_shift(input logic [W-1:0] a, input int k);
        logic [2*W-1:0] wide;
        wide = {{W{1'b0}}, a};
        return wide << k;
    endfunction

    // One full transaction. junk=1 toggles start with garbage during
    // SHIFT/DONE and raises start together with ack; both must be ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [AW-1:0] am, input bit junk);
        int             k;
        int             cycles;
        int             hold;
        logic [2*W-1:0] r;
        k = (int'(am) > W) ? W : int'(am);
        r = ref_shift(a, k);
        check("idle_ready", 32'(ready), 32'd1);
        A     = a;
        amt   = am;
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = W'($urandom);
        amt   = AW'($urandom);
        cycles = 0;
        while (busy && cycles < 40) begin
            if (junk) start = 1'($urandom_range(0, 1));
            tick();
            cycles++;
        end
        check("latency", 32'(cycles), 32'(k));
        check("done", 32'(done), 32'd1);
        check("out", 32'(out), 32'(r[W-1:0]));
        check("spill", 32'(spill), 32'(r[2*W-1:W]));
        check("ovf", 32'(ovf), 32'(|r[2*W-1:W]));
        hold = $urandom_range(1, 4);
        repeat (hold) begin
            if (junk) start = 1'($urandom_range(0, 1));
            tick();
            check("done_hold", 32'(done), 32'd1);
            check("out_hold", 32'(out), 32'(r[W-1:0]));
        end
        ack   = 1'b1;
        start = junk;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        check("ack_ready", 32'(ready), 32'd1);
        check("ack_done", 32'(done), 32'd0);
        check("idle_out_kept", 32'(out), 32'(r[W-1:0]));
        check("idle_spill_kept", 32'(spill), 32'(r[2*W-1:W]));
        tick();
        check("idle_stays", 32'(ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        amt   = '0;
        ack   = 1'b0;
        abort = 1'b0;
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset mid-SHIFT after two shifts, observed with no clock edge.
        A = 8'hFF; amt = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_out", 32'(out), 32'd0);
        check("arst_spill", 32'(spill), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed cases.
        do_op(8'hB5, 4'd3, 1'b0);
        do_op(8'h0F, 4'd4, 1'b0);
        do_op(8'h81, 4'd0, 1'b0);
        do_op(8'hC3, 4'd12, 1'b0);
        do_op(8'h3C, 4'd9, 1'b1);
        do_op(8'h01, 4'd7, 1'b0);

        // Abort on the second SHIFT cycle: no done pulse, cleared result.
        A = 8'h55; amt = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_out", 32'(out), 32'd0);
        check("abort_spill", 32'(spill), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        repeat (3) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end

        // Abort during DONE wins over ack.
        A = 8'hF0; amt = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abd_done", 32'(done), 32'd1);
        abort = 1'b1; ack = 1'b1;
        tick();
        abort = 1'b0; ack = 1'b0;
        check("abd_ready", 32'(ready), 32'd1);
        check("abd_out", 32'(out), 32'd0);

        // Start with abort in IDLE: start dropped.
        A = 8'hAA; amt = 4'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_ready", 32'(ready), 32'd1);
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_out", 32'(out), 32'd0);
        tick();
        check("sa_still_idle", 32'(ready), 32'd1);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_left_seq.md
Name: shift_left_seq

Overview:
Multi-cycle controller that sequences a 1-bit shift-left cell across a WIDTH-bit word, one bit position per clock, for a requested shift amount.
- Accepts a word and amount via start/ready, runs the shifts, then holds the result, the shifted-out bits and an overflow flag until acknowledged.
- Sits between the ALU op decoder and the result mux as the sequencer for shift-left operations.

Parameters:
WIDTH, 8, data word width in bits (>=2)
AMT_W, 4, width of shift-amount input; values > WIDTH clamp to WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
A  input  WIDTH  operand word, latched on accepted start
amt  input  AMT_W  shift amount, latched on accepted start
ack  input  1  consumer accepts result; sampled only in DONE
abort  input  1  synchronous cancel; highest priority after reset
ready  output  1  1 in IDLE only
busy  output  1  1 in SHIFT only
done  output  1  1 in DONE only; out/spill/ovf valid
out  output  WIDTH  shifted word
spill  output  WIDTH  bits shifted out of MSB, most recent in bit 0
ovf  output  1  1 if any shifted-out bit was 1

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: state=IDLE; ready=1, busy=0, done=0, out=0, spill=0, ovf=0; internal counter=0. Reset mid-operation abandons the op immediately, with no done pulse.
- States: IDLE, SHIFT, DONE (2-bit encoding, free choice).
- IDLE, on start=1 at edge E0:
  - out<=A; spill<=0; ovf<=0; cnt<=min(amt,WIDTH).
  - If the clamped amt==0, go to DONE; else go to SHIFT.
- IDLE, start=0: hold all registers.
- SHIFT, each edge:
  - out<={out[WIDTH-2:0],1'b0}
  - spill<={spill[WIDTH-2:0],out[WIDTH-1]}
  - ovf<=ovf|out[WIDTH-1]
  - cnt<=cnt-1
  - When cnt==1 at the edge, that shift is the last; go to DONE.
- Latency: done visible after edge E0+k, where k is the clamped amt. So k=0 gives done in the cycle after E0; k=WIDTH gives WIDTH+1 cycles in total.
- Result for k=WIDTH: out=0, spill=A, ovf=|A.
- DONE: hold out/spill/ovf stable. On ack=1 go to IDLE; outputs keep their values in IDLE until the next accepted start.
- start is ignored outside IDLE. ack is ignored outside DONE.
- abort=1 at any edge: go to IDLE; out, spill, ovf and cnt clear to 0. This overrides start and ack in the same cycle.
- start and abort in the same IDLE cycle: abort wins and the start is dropped.
- ready, busy and done are one-hot decodes of state and are registered (no combinational path from inputs).
- No back-to-back bypass: a new start is accepted at the earliest in the cycle after ack returns the block to IDLE.

Test Plan:
1. Reset with rst_n=0 mid-SHIFT (A=8'hFF, amt=5, after 2 shifts) -> next sample shows ready=1, busy=0, done=0, out=0, spill=0, ovf=0, with no clock edge required.
2. A=8'hB5, amt=3, start 1 cycle -> busy for 3 cycles, then done=1 with out=8'hA8, spill=8'h05, ovf=1; done holds 4 cycles with ack=0; ack=1 -> ready=1 next cycle.
3. A=8'h0F, amt=4 -> out=8'hF0, spill=8'h00, ovf=0, done after 4 edges. A=8'h81, amt=0 -> done in the cycle after start, out=8'h81, spill=0, ovf=0.
4. A=8'hC3, amt=12 (clamped to 8) -> 8 busy cycles; out=8'h00, spill=8'hC3, ovf=1.
5. Start A=8'h55, amt=6; abort=1 on the 2nd SHIFT cycle -> IDLE next cycle with out=0, no done pulse. Start pulses held during SHIFT/DONE are ignored (result unchanged). Simultaneous start+abort in IDLE -> remains IDLE.
6. Back-to-back: ack and the next start asserted together in DONE -> start ignored. Start re-asserted the following cycle with A=8'h01, amt=7 -> out=8'h80, spill=0, ovf=0.
